// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the five-stage pipeline
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   IDEX_opcode_out             opcode of the instruction in EX
//   IDEX_write_reg_out          rd of the instruction in EX
//   IFID_rs1, IFID_rs2          source registers of the instruction in ID
//   EXMEM_pc_replace_out        taken branch/jump needs a PC redirect
//   mem_req, mem_ready          data memory access in flight / completing
//   pc_write, pc_redirect       PC enable and PC target-mux select
//   IFID_write, IFID_flush      IF/ID enable and NOP insert
//   IDEX_act, EXMEM_act,
//   MEMWB_act                   valid qualifiers for the stage registers
//   stage_hold                  freezes ID/EX, EX/MEM and MEM/WB
//   mem_error                   sticky data memory timeout flag
//   stall_cnt, flush_cnt        performance counters
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       IDEX_opcode_out,
    input  logic [4:0]       IDEX_write_reg_out,
    input  logic [4:0]       IFID_rs1,
    input  logic [4:0]       IFID_rs2,
    input  logic             EXMEM_pc_replace_out,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_redirect,
    output logic             IFID_write,
    output logic             IFID_flush,
    output logic             IDEX_act,
    output logic             EXMEM_act,
    output logic             MEMWB_act,
    output logic             stage_hold,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    localparam logic [6:0] OP_LOAD = 7'b0000011;

    // wcnt never exceeds TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int              WCNT_W    = $clog2(TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    logic [1:0]        state, state_nxt;
    logic              pending, pending_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic              stall_inc, flush_inc, err_set;
    logic              load_use;
    logic              pend_now;

    assign load_use = (IDEX_opcode_out == OP_LOAD) &&
                      (IDEX_write_reg_out != 5'd0) &&
                      ((IDEX_write_reg_out == IFID_rs1) ||
                       (IDEX_write_reg_out == IFID_rs2));

    // A redirect seen in the same cycle as release must still be honoured.
    assign pend_now = pending | EXMEM_pc_replace_out;

    always_comb begin
        pc_write    = 1'b1;
        pc_redirect = 1'b0;
        IFID_write  = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_act    = 1'b1;
        EXMEM_act   = 1'b1;
        MEMWB_act   = 1'b1;
        stage_hold  = 1'b0;
        state_nxt   = state;
        pending_nxt = pending;
        wcnt_nxt    = wcnt;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        err_set     = 1'b0;

        case (state)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    pc_write    = 1'b0;
                    IFID_write  = 1'b0;
                    MEMWB_act   = 1'b0;
                    stage_hold  = 1'b1;
                    pending_nxt = EXMEM_pc_replace_out;
                    wcnt_nxt    = WCNT_W'(1);
                    state_nxt   = ST_MEM_WAIT;
                end else if (EXMEM_pc_replace_out) begin
                    pc_redirect = 1'b1;
                    IFID_flush  = 1'b1;
                    IDEX_act    = 1'b0;
                    EXMEM_act   = 1'b0;
                    flush_inc   = 1'b1;
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    IFID_write = 1'b0;
                    IDEX_act   = 1'b0;
                    stall_inc  = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                pc_write    = 1'b0;
                IFID_write  = 1'b0;
                MEMWB_act   = 1'b0;
                stage_hold  = 1'b1;
                stall_inc   = 1'b1;
                pending_nxt = pend_now;
                if (mem_ready) begin
                    stage_hold = 1'b0;
                    MEMWB_act  = 1'b1;
                    wcnt_nxt   = '0;
                    state_nxt  = pend_now ? ST_REDIRECT : ST_RUN;
                end else if (wcnt == WCNT_LAST) begin
                    // Abandon the access: unfreeze but drop the writeback.
                    stage_hold = 1'b0;
                    err_set    = 1'b1;
                    wcnt_nxt   = '0;
                    state_nxt  = pend_now ? ST_REDIRECT : ST_RUN;
                end else begin
                    wcnt_nxt = wcnt + WCNT_W'(1);
                end
            end

            ST_REDIRECT: begin
                pc_redirect = 1'b1;
                IFID_flush  = 1'b1;
                IDEX_act    = 1'b0;
                EXMEM_act   = 1'b0;
                flush_inc   = 1'b1;
                pending_nxt = 1'b0;
                state_nxt   = ST_RUN;
            end

            default: begin
                state_nxt   = ST_RUN;
                pending_nxt = 1'b0;
                wcnt_nxt    = '0;
            end
        endcase

        // During reset the pipeline is held empty: nothing advances, IF/ID loads a NOP.
        if (reset) begin
            pc_write    = 1'b0;
            pc_redirect = 1'b0;
            IFID_write  = 1'b0;
            IFID_flush  = 1'b1;
            IDEX_act    = 1'b0;
            EXMEM_act   = 1'b0;
            MEMWB_act   = 1'b0;
            stage_hold  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            pending   <= 1'b0;
            wcnt      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            mem_error <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            wcnt    <= wcnt_nxt;
            if (stall_inc) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (err_set) begin
                mem_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - testbench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 32;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] AL = 7'b0110011;

    // {pc_write, pc_redirect, IFID_write, IFID_flush, IDEX_act, EXMEM_act, MEMWB_act, stage_hold}
    localparam logic [7:0] O_RUN = 8'b1010_1110;
    localparam logic [7:0] O_RST = 8'b0001_0000;
    localparam logic [7:0] O_RDR = 8'b1111_0010;
    localparam logic [7:0] O_BUB = 8'b0000_0110;
    localparam logic [7:0] O_FRZ = 8'b0000_1101;
    localparam logic [7:0] O_REL = 8'b0000_1110;
    localparam logic [7:0] O_TOR = 8'b0000_1100;

    logic             clk;
    logic             reset;
    logic [6:0]       IDEX_opcode_out;
    logic [4:0]       IDEX_write_reg_out;
    logic [4:0]       IFID_rs1;
    logic [4:0]       IFID_rs2;
    logic             EXMEM_pc_replace_out;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_redirect;
    logic             IFID_write;
    logic             IFID_flush;
    logic             IDEX_act;
    logic             EXMEM_act;
    logic             MEMWB_act;
    logic             stage_hold;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [7:0]       outs;

    assign outs = {pc_write, pc_redirect, IFID_write, IFID_flush,
                   IDEX_act, EXMEM_act, MEMWB_act, stage_hold};

    pipeline_hazard_ctrl #(
        .TIMEOUT (4),
        .CNT_W   (CNT_W)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .IDEX_opcode_out      (IDEX_opcode_out),
        .IDEX_write_reg_out   (IDEX_write_reg_out),
        .IFID_rs1             (IFID_rs1),
        .IFID_rs2             (IFID_rs2),
        .EXMEM_pc_replace_out (EXMEM_pc_replace_out),
        .mem_req              (mem_req),
        .mem_ready            (mem_ready),
        .pc_write             (pc_write),
        .pc_redirect          (pc_redirect),
        .IFID_write           (IFID_write),
        .IFID_flush           (IFID_flush),
        .IDEX_act             (IDEX_act),
        .EXMEM_act            (EXMEM_act),
        .MEMWB_act            (MEMWB_act),
        .stage_hold           (stage_hold),
        .mem_error            (mem_error),
        .stall_cnt            (stall_cnt),
        .flush_cnt            (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rep;
        logic       mreq;
        logic       mrdy;
        logic [7:0] exp_o;
        int         exp_stall;
        int         exp_flush;
        logic       exp_err;
    } vec_t;

    localparam int NV = 39;
    vec_t tbl [NV];

    int n_total = 0;
    int n_pass  = 0;

    function automatic vec_t mk(logic rst, logic [6:0] op, logic [4:0] rd,
                                logic [4:0] rs1, logic [4:0] rs2, logic rep,
                                logic mreq, logic mrdy, logic [7:0] o,
                                int s, int f, logic e);
        vec_t v;
        v.rst = rst; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.rep = rep; v.mreq = mreq; v.mrdy = mrdy;
        v.exp_o = o; v.exp_stall = s; v.exp_flush = f; v.exp_err = e;
        return v;
    endfunction

    task automatic check(string name, int row, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s step %0d: got %0h expected %0h", name, row, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of inputs just after the edge, check just before the next one.
    task automatic apply(vec_t v, int row);
        @(posedge clk);
        #1;
        reset                = v.rst;
        IDEX_opcode_out      = v.op;
        IDEX_write_reg_out   = v.rd;
        IFID_rs1             = v.rs1;
        IFID_rs2             = v.rs2;
        EXMEM_pc_replace_out = v.rep;
        mem_req              = v.mreq;
        mem_ready            = v.mrdy;
        @(negedge clk);
        check("outputs",   row, {24'd0, outs}, {24'd0, v.exp_o});
        check("stall_cnt", row, stall_cnt, v.exp_stall);
        check("flush_cnt", row, flush_cnt, v.exp_flush);
        check("mem_error", row, {31'd0, mem_error}, {31'd0, v.exp_err});
    endtask

    initial begin
        //              rst op  rd rs1 rs2 rep mrq mrd  out    stl fl err
        tbl[0]  = mk(1, AL, 0, 0, 0, 0, 0, 0, O_RST, 0,  0, 0);
        tbl[1]  = mk(0, AL, 0, 0, 0, 0, 0, 0, O_RUN, 0,  0, 0);
        tbl[2]  = mk(0, LD, 5, 0, 5, 0, 0, 0, O_BUB, 0,  0, 0);  // load-use on rs2
        tbl[3]  = mk(0, AL, 5, 0, 5, 0, 0, 0, O_RUN, 1,  0, 0);
        tbl[4]  = mk(0, LD, 0, 0, 0, 0, 0, 0, O_RUN, 1,  0, 0);  // rd = x0: no hazard
        tbl[5]  = mk(0, LD, 7, 7, 0, 0, 0, 0, O_BUB, 1,  0, 0);  // load-use on rs1
        tbl[6]  = mk(0, LD, 5, 0, 5, 1, 0, 0, O_RDR, 2,  0, 0);  // redirect beats load-use
        tbl[7]  = mk(0, AL, 0, 0, 0, 0, 0, 0, O_RUN, 2,  1, 0);
        tbl[8]  = mk(0, AL, 0, 0, 0, 0, 1, 0, O_FRZ, 2,  1, 0);  // memory wait, ready 3 later
        tbl[9]  = mk(0, AL, 0, 0, 0, 0, 1, 0, O_FRZ, 2,  1, 0);
        tbl[10] = mk(0, AL, 0, 0, 0, 0, 1, 0, O_FRZ, 3,  1, 0);
        tbl[11] = mk(0, AL, 0, 0, 0, 0, 1, 1, O_REL, 4,  1, 0);
        tbl[12] = mk(0, AL, 0, 0, 0, 0, 0, 0, O_RUN, 5,  1, 0);
        tbl[13] = mk(0, AL, 0, 0, 0, 0, 1, 0, O_FRZ, 5,  1, 0);  // deferred redirect
        tbl[14] = mk(0, AL, 0, 0, 0, 1, 1, 0, O_FRZ, 5,  1, 0);
        tbl[15] = mk(0, AL, 0, 0, 0, 0, 1, 0, O_FRZ, 6,  1, 0);
        tbl[16] = mk(0, AL, 0, 0, 0, 0, 1, 1, O_REL, 7,  1, 0);  // ready on last wait count
        tbl[17] = mk(0, AL, 0, 0, 0, 0, 0, 0, O_RDR, 8,  1, 0);
        tbl[18] = mk(0, AL, 0, 0, 0, 0, 0, 0, O_RUN, 8,  2, 0);
        tbl[19] = mk(0, AL, 0, 0, 0, 1, 1, 0, O_FRZ, 8,  2, 0);  // redirect coincides with req
        tbl[20] = mk(0, AL, 0, 0, 0, 0, 1, 1, O_REL, 8,  2, 0);
        tbl[21] = mk(0, LD, 5, 5, 0, 0, 0, 0, O_RDR, 9,  2, 0);  // REDIRECT ignores load-use
        tbl[22] = mk(0, AL, 0, 0, 0, 0, 0, 0, O_RUN, 9,  3, 0);
        tbl[23] = mk(0, AL, 0, 0, 0, 0, 1, 0, O_FRZ, 9,  3, 0);  // timeout
        tbl[24] = mk(0, AL, 0, 0, 0, 0, 1, 0, O_FRZ, 9,  3, 0);
        tbl[25] = mk(0, AL, 0, 0, 0, 0, 1, 0, O_FRZ, 10, 3, 0);
        tbl[26] = mk(0, AL, 0, 0, 0, 0, 1, 0, O_TOR, 11, 3, 0);
        tbl[27] = mk(0, AL, 0, 0, 0, 0, 0, 0, O_RUN, 12, 3, 1);
        tbl[28] = mk(0, LD, 5, 0, 5, 0, 0, 0, O_BUB, 12, 3, 1);  // error stays sticky
        tbl[29] = mk(0, AL, 0, 0, 0, 0, 0, 0, O_RUN, 13, 3, 1);
        tbl[30] = mk(0, AL, 0, 0, 0, 0, 1, 0, O_FRZ, 13, 3, 1);  // reset mid-stall
        tbl[31] = mk(0, AL, 0, 0, 0, 1, 1, 0, O_FRZ, 13, 3, 1);
        tbl[32] = mk(1, AL, 0, 0, 0, 1, 1, 0, O_RST, 14, 3, 1);
        tbl[33] = mk(0, AL, 0, 0, 0, 0, 0, 0, O_RUN, 0,  0, 0);
        tbl[34] = mk(0, AL, 0, 0, 0, 0, 0, 0, O_RUN, 0,  0, 0);
        tbl[35] = mk(0, AL, 0, 0, 0, 1, 1, 0, O_FRZ, 0,  0, 0);  // reset while in REDIRECT
        tbl[36] = mk(0, AL, 0, 0, 0, 0, 1, 1, O_REL, 0,  0, 0);
        tbl[37] = mk(1, AL, 0, 0, 0, 0, 0, 0, O_RST, 1,  0, 0);
        tbl[38] = mk(0, AL, 0, 0, 0, 0, 0, 0, O_RUN, 0,  0, 0);

        reset                = 1'b1;
        IDEX_opcode_out      = AL;
        IDEX_write_reg_out   = 5'd0;
        IFID_rs1             = 5'd0;
        IFID_rs2             = 5'd0;
        EXMEM_pc_replace_out = 1'b0;
        mem_req              = 1'b0;
        mem_ready            = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i], i);
        end

        // Redirect pending when the access times out: REDIRECT still follows release.
        apply(mk(0, AL, 0, 0, 0, 1, 1, 0, O_FRZ, 0, 0, 0), 100);
        apply(mk(0, AL, 0, 0, 0, 0, 1, 0, O_FRZ, 0, 0, 0), 101);
        apply(mk(0, AL, 0, 0, 0, 0, 1, 0, O_FRZ, 1, 0, 0), 102);
        apply(mk(0, AL, 0, 0, 0, 0, 1, 0, O_TOR, 2, 0, 0), 103);
        apply(mk(0, AL, 0, 0, 0, 0, 0, 0, O_RDR, 3, 0, 1), 104);
        apply(mk(0, AL, 0, 0, 0, 0, 0, 0, O_RUN, 3, 1, 1), 105);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage RISC-V pipeline. It drives the per-stage write enables and `act` (valid) qualifiers of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards, applies branch/jump redirects signalled by `EXMEM_pc_replace_out`, and freezes the pipeline while data memory is busy, with a timeout. It also keeps stall and flush counters for performance debug.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum MEM_WAIT cycles before abandoning the access (≥2).
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  reset, synchronous and active-high.
- `IDEX_opcode_out`  in  7  opcode of the instruction in EX.
- `IDEX_write_reg_out`  in  5  rd of the instruction in EX.
- `IFID_rs1`, `IFID_rs2`  in  5 each  source registers of the instruction in ID.
- `EXMEM_pc_replace_out`  in  1  taken branch/jump resolved; redirect required.
- `mem_req`  in  1  MEM-stage load/store in flight.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `pc_write`  out  1  PC register enable.
- `pc_redirect`  out  1  PC mux selects the branch target.
- `IFID_write`  out  1  IF/ID register enable.
- `IFID_flush`  out  1  IF/ID loads a NOP.
- `IDEX_act`, `EXMEM_act`, `MEMWB_act`  out  1 each  `act` qualifiers fed to the stage registers.
- `stage_hold`  out  1  freezes ID/EX, EX/MEM and MEM/WB (hold contents).
- `mem_error`  out  1  sticky; set on timeout.
- `stall_cnt`, `flush_cnt`  out  CNT_W each  performance counters.

## Operation
- `load_use` = (`IDEX_opcode_out` == 7'b0000011) && (`IDEX_write_reg_out` != 0) && (`IDEX_write_reg_out` == `IFID_rs1` || `IDEX_write_reg_out` == `IFID_rs2`).
- Default outputs: `pc_write`, `IFID_write`, and all three `act` signals are 1. `pc_redirect`, `IFID_flush` and `stage_hold` are 0.
- The FSM has three states: RUN, MEM_WAIT and REDIRECT. There is also a registered `pending` bit and a wait counter `wcnt`.
- **RUN.** Conditions are evaluated in priority order; the first match applies.
  1. `mem_req` && !`mem_ready`: freeze. `pc_write`, `IFID_write`, `MEMWB_act` = 0 and `stage_hold` = 1. `pending` ← `EXMEM_pc_replace_out`. `wcnt` ← 1. Next state is MEM_WAIT.
  2. `EXMEM_pc_replace_out`: redirect. `pc_redirect` = 1, `IFID_flush` = 1, `IDEX_act` = 0, `EXMEM_act` = 0. `flush_cnt` increments.
  3. `load_use`: bubble. `pc_write` = 0, `IFID_write` = 0, `IDEX_act` = 0. `stall_cnt` increments.
- **MEM_WAIT.** Freeze outputs as in RUN rule 1. `stall_cnt` increments every cycle. `pending` ← `pending` | `EXMEM_pc_replace_out`.
  - `mem_ready`: release. `stage_hold` = 0 and `MEMWB_act` = 1; `pc_write` and `IFID_write` stay 0 this cycle. Next state is REDIRECT if `pending` (including this cycle's input), else RUN.
  - Otherwise, if `wcnt` == TIMEOUT−1: `mem_error` ← 1. Release with `MEMWB_act` = 0 (access abandoned, no writeback). Leave per the same `pending` rule.
  - Otherwise `wcnt` increments.
- **REDIRECT.** Redirect outputs as in RUN rule 2. `pending` ← 0. `flush_cnt` increments. Next state is RUN.
- Counters wrap modulo 2^CNT_W.
- `mem_error` clears only on `reset`.

## Timing
- Outputs are combinational from state and inputs. The next state, `pending`, `wcnt`, counters and `mem_error` are registered.
- Load-use costs exactly 1 bubble cycle.
- Redirect costs 1 cycle and kills the IF, ID and EX instructions.
- A memory stall lasts N cycles for `mem_ready` arriving N cycles after the `mem_req` cycle; at most TIMEOUT−1 frozen cycles.
- A redirect coinciding with or arriving during a memory stall is deferred. It is applied in REDIRECT, exactly 1 cycle after release.
- While `reset` = 1: `pc_write`, `IFID_write`, all `act` signals, `pc_redirect` and `stage_hold` = 0; `IFID_flush` = 1.
- On the first cycle after reset: state RUN, `pending` = 0, `wcnt` = 0, counters = 0, `mem_error` = 0.
- Reset asserted mid-MEM_WAIT or in REDIRECT discards the pending redirect and the in-flight access.

## Test plan
- **Load-use.** `IDEX_opcode_out` = 0000011, rd = 5, `IFID_rs2` = 5, no memory activity → exactly 1 cycle with `pc_write` = `IFID_write` = `IDEX_act` = 0; `stall_cnt` = 1. Same stimulus with rd = 0 → no stall.
- **Branch redirect.** `EXMEM_pc_replace_out` pulsed 1 cycle while `load_use` is true → `pc_redirect` = `IFID_flush` = 1, `IDEX_act` = `EXMEM_act` = 0, `pc_write` = 1; `flush_cnt` = 1, `stall_cnt` unchanged.
- **Memory wait.** `mem_req` = 1, `mem_ready` rises 3 cycles later → `stage_hold` = 1 for 3 cycles; release cycle has `MEMWB_act` = 1; `stall_cnt` = 3; state returns to RUN.
- **Deferred redirect.** `EXMEM_pc_replace_out` = 1 in the second MEM_WAIT cycle, `mem_ready` in the fourth → no `pc_redirect` during the wait; exactly one `pc_redirect` cycle immediately after release; `flush_cnt` = 1.
- **Timeout.** TIMEOUT = 4, `mem_req` held with `mem_ready` = 0 → 3 frozen cycles, then `mem_error` = 1 and release with `MEMWB_act` = 0. `mem_error` stays 1 through later traffic until `reset`.
- **Reset mid-stall.** `reset` asserted in MEM_WAIT with a redirect pending → enables 0 and `IFID_flush` = 1 during reset; afterward RUN, counters 0, and no `pc_redirect` issued.
